// File: rtl/line_drain_serializer.sv
// rtl/line_drain_serializer.sv - pops cache lines from the async FIFO read side and emits them as LSB-first beats
// Optional LINE_DRAIN_PERF_EN adds saturating perf_lines / perf_stall counters.
module line_drain_serializer #(
  parameter int CASH_STR_WIDTH = 64,
  parameter int BEAT_WIDTH     = 16,
  localparam int BEATS         = CASH_STR_WIDTH / BEAT_WIDTH,
  localparam int BEAT_IDX_W    = $clog2(BEATS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      drain_en,
  input  logic                      fifo_empty,
  input  logic [CASH_STR_WIDTH-1:0] fifo_dout,
  output logic                      fifo_read,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [BEAT_WIDTH-1:0]     mem_data,
  output logic [BEAT_IDX_W-1:0]     mem_beat,
  output logic                      mem_last,
  output logic                      busy
`ifdef LINE_DRAIN_PERF_EN
  ,
  output logic [15:0]               perf_lines,
  output logic [15:0]               perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [CASH_STR_WIDTH-1:0] line_buf;
  logic [BEAT_IDX_W-1:0]     beat_q;
  logic [BEAT_IDX_W-1:0]     beat_d;
  logic                      load_line;
  logic                      line_done;
  logic                      stall;
  logic [BEAT_WIDTH-1:0]     beat_words [BEATS];

  // Slice the held line into beats once so the output mux is a plain array lookup.
  for (genvar g = 0; g < BEATS; g++) begin : g_words
    assign beat_words[g] = line_buf[g*BEAT_WIDTH +: BEAT_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_buf <= '0;
    end else if (load_line) begin
      line_buf <= fifo_dout;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    fifo_read = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    mem_last  = 1'b0;
    load_line = 1'b0;
    line_done = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset is folded in so no pop strobe can leak out while reset is held.
        fifo_read = drain_en & ~fifo_empty & ~reset;
        if (fifo_read) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_line = 1'b1;
        beat_d    = '0;
        state_d   = SEND;
      end
      SEND: begin
        mem_valid = 1'b1;
        mem_data  = beat_words[beat_q];
        mem_last  = (beat_q == BEAT_IDX_W'(BEATS - 1));
        if (mem_ready) begin
          if (mem_last) begin
            beat_d    = '0;
            state_d   = IDLE;
            line_done = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_IDX_W'(1);
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_beat = beat_q;
  assign busy     = (state_q != IDLE);

`ifdef LINE_DRAIN_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lines <= '0;
      perf_stall <= '0;
    end else begin
      if (line_done && (perf_lines != 16'hFFFF)) begin
        perf_lines <= perf_lines + 16'd1;
      end
      if (stall && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = line_done ^ stall;
`endif

endmodule

// File: tb/tb_line_drain_serializer.sv
// tb/tb_line_drain_serializer.sv - randomized self-checking bench for line_drain_serializer
// Honours LINE_DRAIN_PERF_EN when the design is built with it.
module tb_line_drain_serializer;

  localparam int LW    = 64;
  localparam int BW    = 16;
  localparam int BEATS = LW / BW;

  typedef struct {
    logic [BW-1:0] data;
    logic [1:0]    beat;
    logic          last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          drain_en;
  logic          fifo_empty;
  logic [LW-1:0] fifo_dout;
  logic          fifo_read;
  logic          mem_valid;
  logic          mem_ready;
  logic [BW-1:0] mem_data;
  logic [1:0]    mem_beat;
  logic          mem_last;
  logic          busy;
`ifdef LINE_DRAIN_PERF_EN
  logic [15:0]   perf_lines;
  logic [15:0]   perf_stall;
`endif

  line_drain_serializer #(.CASH_STR_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .drain_en   (drain_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .mem_beat   (mem_beat),
    .mem_last   (mem_last),
    .busy       (busy)
`ifdef LINE_DRAIN_PERF_EN
    ,
    .perf_lines (perf_lines),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [LW-1:0] line_q [$];
  beat_t         exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            load_cyc = -10;
  int            last_read_cyc = -10;
  int            first_read_cyc = -1;
  int            first_valid_cyc = -1;
  int            last_cyc = -1;
  int            read_count = 0;
  int            lines_done = 0;
  int            lines_model = 0;
  int            stall_model = 0;
  logic          prev_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data;
  logic [1:0]    prev_beat;
  logic          prev_last;

  task automatic push_line(input logic [LW-1:0] v);
    line_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: observe at the falling edge, then model the FIFO's registered read port.
  task automatic tick();
    logic          pop_now;
    logic [LW-1:0] popped;
    logic          exp_valid;
    beat_t         e;
    beat_t         b;
    pop_now = 1'b0;
    popped  = '0;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0) && (cyc != load_cyc);
    checks++;
    if (busy !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_q.size() != 0);
    end
    checks++;
    if (mem_valid !== exp_valid) begin
      errors++;
      $display("FAIL mem_valid cyc=%0d got=%b exp=%b", cyc, mem_valid, exp_valid);
    end
    if (prev_stall) begin
      checks++;
      if (!mem_valid || mem_data !== prev_data || mem_beat !== prev_beat || mem_last !== prev_last) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, mem_data, mem_beat, mem_last,
                 prev_data, prev_beat, prev_last);
      end
    end
    if (mem_valid && !prev_valid) first_valid_cyc = cyc;
    if (mem_valid && mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d got=%h exp=none", cyc, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_data !== e.data || mem_beat !== e.beat || mem_last !== e.last) begin
          errors++;
          $display("FAIL beat cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, mem_data, mem_beat, mem_last,
                   e.data, e.beat, e.last);
        end
        if (e.last) begin
          lines_done++;
          last_cyc = cyc;
          if (lines_model < 16'hFFFF) lines_model++;
        end
      end
    end
    if (mem_valid && !mem_ready && stall_model < 16'hFFFF) stall_model++;
    prev_valid = mem_valid;
    prev_stall = mem_valid && !mem_ready;
    prev_data  = mem_data;
    prev_beat  = mem_beat;
    prev_last  = mem_last;
    if (fifo_read) begin
      checks++;
      if (fifo_empty || !drain_en || reset || exp_q.size() != 0 || line_q.size() == 0) begin
        errors++;
        $display("FAIL illegal_read cyc=%0d got=1 exp=0 (empty=%b drain=%b inflight=%0d)", cyc,
                 fifo_empty, drain_en, exp_q.size());
      end
      if (line_q.size() != 0) begin
        popped = line_q.pop_front();
        pop_now = 1'b1;
        for (int i = 0; i < BEATS; i++) begin
          b.data = BW'((popped >> (i * BW)) & 64'hFFFF);
          b.beat = 2'(i);
          b.last = (i == BEATS - 1);
          exp_q.push_back(b);
        end
      end
      read_count++;
      last_read_cyc = cyc;
      load_cyc = cyc + 1;
      if (first_read_cyc < 0) first_read_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now) fifo_dout = popped;
    fifo_empty = (line_q.size() == 0);
  endtask

  task automatic run_until_lines(input int target, input int budget);
    int n;
    n = 0;
    while (lines_done < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (lines_done < target) begin
      errors++;
      $display("FAIL timeout_lines got=%0d exp=%0d", lines_done, target);
    end
  endtask

  task automatic wait_beat(input int idx, input int budget);
    int n;
    n = 0;
    while (!(mem_valid && mem_beat == 2'(idx)) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(mem_valid && mem_beat == 2'(idx))) begin
      errors++;
      $display("FAIL timeout_beat got=%0d exp=%0d", mem_beat, idx);
    end
  endtask

  task automatic check_perf();
`ifdef LINE_DRAIN_PERF_EN
    checks++;
    if (perf_lines !== 16'(lines_model) || perf_stall !== 16'(stall_model)) begin
      errors++;
      $display("FAIL perf got=%0d/%0d exp=%0d/%0d", perf_lines, perf_stall, lines_model, stall_model);
    end
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (fifo_read !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0 || mem_beat !== 2'd0 ||
        mem_data !== 16'h0 || mem_last !== 1'b0) begin
      errors++;
      $display("FAIL %s got=rd%b v%b b%b beat%0d d%h l%b exp=all_zero", name, fifo_read, mem_valid,
               busy, mem_beat, mem_data, mem_last);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drain_en = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    mem_ready = 1'b0;
    #1;
    check_idle_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) tick();
    check_idle_outputs("idle_empty");
    check_perf();
  endtask

  task automatic test_single_line();
    int base;
    base = lines_done;
    mem_ready = 1'b1;
    push_line(64'h4444_3333_2222_1111);
    run_until_lines(base + 1, 40);
    checks++;
    if (first_valid_cyc - last_read_cyc != 2) begin
      errors++;
      $display("FAIL first_beat_latency got=%0d exp=2", first_valid_cyc - last_read_cyc);
    end
    checks++;
    if (last_cyc - first_valid_cyc != BEATS - 1) begin
      errors++;
      $display("FAIL beat_spacing got=%0d exp=%0d", last_cyc - first_valid_cyc, BEATS - 1);
    end
    tick();
    check_perf();
  endtask

  task automatic test_stall();
    int base;
    int stall_base;
    base = lines_done;
    mem_ready = 1'b1;
    push_line(64'h4444_3333_2222_1111);
    wait_beat(1, 20);
    stall_base = stall_model;
    mem_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (mem_beat !== 2'd1 || mem_data !== 16'h2222) begin
      errors++;
      $display("FAIL stall_hold got=%0d/%h exp=1/2222", mem_beat, mem_data);
    end
    mem_ready = 1'b1;
    run_until_lines(base + 1, 20);
    checks++;
    if (stall_model - stall_base != 3) begin
      errors++;
      $display("FAIL stall_cycles got=%0d exp=3", stall_model - stall_base);
    end
`ifdef LINE_DRAIN_PERF_EN
    checks++;
    if (perf_stall !== 16'(stall_base + 3)) begin
      errors++;
      $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, stall_base + 3);
    end
`endif
    tick();
    check_perf();
  endtask

  task automatic test_back_to_back();
    int base;
    int rd_base;
    int ln_base;
    base = lines_done;
    rd_base = read_count;
    ln_base = lines_model;
    mem_ready = 1'b1;
    first_read_cyc = -1;
    push_line({$urandom, $urandom});
    push_line({$urandom, $urandom});
    run_until_lines(base + 2, 40);
    // Inclusive span: two lines at BEATS+2 cycles each.
    checks++;
    if (last_cyc - first_read_cyc + 1 != 2 * (BEATS + 2)) begin
      errors++;
      $display("FAIL b2b_span got=%0d exp=%0d", last_cyc - first_read_cyc + 1, 2 * (BEATS + 2));
    end
    checks++;
    if (read_count - rd_base != 2) begin
      errors++;
      $display("FAIL b2b_reads got=%0d exp=2", read_count - rd_base);
    end
`ifdef LINE_DRAIN_PERF_EN
    checks++;
    if (perf_lines !== 16'(ln_base + 2)) begin
      errors++;
      $display("FAIL perf_lines got=%0d exp=%0d", perf_lines, ln_base + 2);
    end
`endif
    tick();
    check_perf();
  endtask

  task automatic test_drain_gate();
    int base;
    int rd_base;
    base = lines_done;
    rd_base = read_count;
    mem_ready = 1'b1;
    drain_en = 1'b1;
    push_line({$urandom, $urandom});
    push_line({$urandom, $urandom});
    wait_beat(1, 20);
    drain_en = 1'b0;
    run_until_lines(base + 1, 20);
    repeat (10) tick();
    checks++;
    if (read_count - rd_base != 1 || busy !== 1'b0 || line_q.size() != 1) begin
      errors++;
      $display("FAIL drain_gate got=reads%0d busy%b queued%0d exp=reads1 busy0 queued1",
               read_count - rd_base, busy, line_q.size());
    end
    drain_en = 1'b1;
    run_until_lines(base + 2, 20);
    checks++;
    if (read_count - rd_base != 2) begin
      errors++;
      $display("FAIL drain_resume got=%0d exp=2", read_count - rd_base);
    end
    tick();
    check_perf();
  endtask

  task automatic test_random();
    int n;
    int target;
    int k;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      target = lines_done + n;
      for (int j = 0; j < n; j++) push_line({$urandom, $urandom});
      k = 0;
      while (lines_done < target && k < 200) begin
        mem_ready = ($urandom % 4) != 0;
        drain_en = ($urandom % 5) != 0;
        tick();
        k++;
      end
      checks++;
      if (lines_done < target) begin
        errors++;
        $display("FAIL random_round%0d got=%0d exp=%0d", r, lines_done, target);
      end
      mem_ready = 1'b1;
      drain_en = 1'b1;
    end
    tick();
    check_perf();
  endtask

  task automatic test_reset_mid();
    int base;
    mem_ready = 1'b1;
    drain_en = 1'b1;
    push_line(64'hDEAD_BEEF_CAFE_F00D);
    wait_beat(2, 20);
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_mid_async");
    exp_q.delete();
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    lines_model = 0;
    stall_model = 0;
    @(posedge clk);
    #1;
    cyc++;
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("after_reset_idle");
    check_perf();
    base = lines_done;
    push_line(64'h0123_4567_89AB_CDEF);
    wait_beat(0, 10);
    checks++;
    if (mem_data !== 16'hCDEF) begin
      errors++;
      $display("FAIL restart_beat0 got=%h exp=cdef", mem_data);
    end
    run_until_lines(base + 1, 20);
    tick();
    check_perf();
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_stall();
    test_back_to_back();
    test_drain_gate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
